uart_cmd_initiator: RTL and testbench

- Host-side initiator for the memory-access UART command protocol served by uart_controller.
- Takes single read/write requests from a local client and serializes each into a command frame through a byte-level UART transmitter.
- For reads, collects the 16-bit response from a byte-level UART receiver, with timeout.
- Used in loopback/self-test builds and in a second FPGA that drives the memory target over UART.

---
 rtl/uart_cmd_initiator.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_cmd_initiator.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_initiator.sv
// -----------------------------------------------------------------------------
// uart_cmd_initiator
// Host-side initiator for the memory-access UART command protocol. A single
// read or write request from a local client is serialised into a command
// frame (CMD, [ADDR_HI], ADDR_LO, [DATA_HI, DATA_LO]) through a byte-level
// UART transmitter. For reads, the two response bytes (MSB first) are
// collected from a byte-level UART receiver. If the response stalls, the read
// is aborted by a timeout.
//
// Ports
//   clk, resetn            system clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (ready only while idle)
//   req_write, req_spram   request kind and target memory type
//   req_select             block select (zero-extended to 6 bits in CMD)
//   req_addr, req_wdata    address (BRAM uses [7:0]) and write data
//   rsp_valid              one-cycle completion pulse
//   rsp_data               read data; 0 for writes and timeouts; held
//   rsp_timeout            qualifies rsp_valid: the read was aborted
//   tx_data/tx_valid       byte and one-cycle strobe to the transmitter
//   tx_busy                transmitter busy (rises the cycle after tx_valid)
//   rx_data/rx_valid       byte and one-cycle strobe from the receiver
//   busy                   high whenever a transaction is in progress
// -----------------------------------------------------------------------------
module uart_cmd_initiator #(
  parameter int MEM_SELECT_BITS = 5,
  parameter int TIMEOUT_CYCLES  = 480_000
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic                       req_spram,
  input  logic [MEM_SELECT_BITS-1:0] req_select,
  input  logic [13:0]                req_addr,
  input  logic [15:0]                req_wdata,
  output logic                       rsp_valid,
  output logic [15:0]                rsp_data,
  output logic                       rsp_timeout,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_busy,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic                       busy
);

  localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    SEND_CMD     = 4'd1,
    SEND_ADDR_HI = 4'd2,
    SEND_ADDR_LO = 4'd3,
    SEND_DATA_HI = 4'd4,
    SEND_DATA_LO = 4'd5,
    TX_DRAIN     = 4'd6,
    RX_HI        = 4'd7,
    RX_LO        = 4'd8,
    RESP         = 4'd9
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic                       r_write;
  logic                       r_spram;
  logic [MEM_SELECT_BITS-1:0] r_select;
  logic [13:0]                r_addr;
  logic [15:0]                r_wdata;
  logic [7:0]                 r_tx_data;
  logic                       r_tx_valid;
  logic [7:0]                 r_rx_hi;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_rsp_valid;
  logic [15:0]                r_rsp_data;
  logic                       r_rsp_timeout;
  logic                       r_req_ready;
  logic                       r_busy;

  logic                       w_accept;
  logic                       w_send;
  logic [7:0]                 w_byte;
  logic                       w_in_rx;
  logic                       w_expire;
  logic                       w_enter_resp;
  logic [15:0]                w_rsp_data;
  logic                       w_rsp_timeout;

  assign req_ready   = r_req_ready;
  assign busy        = r_busy;
  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_timeout = r_rsp_timeout;

  assign w_accept     = req_valid && r_req_ready;
  assign w_in_rx      = (r_state == RX_HI) || (r_state == RX_LO);
  assign w_expire     = (r_cnt == CNT_LAST);
  assign w_enter_resp = (w_next == RESP) && (r_state != RESP);

  // Byte to transmit in the current send state.
  always_comb begin
    w_byte = r_tx_data;
    case (r_state)
      SEND_CMD:     w_byte = {r_write, r_spram, 6'(r_select)};
      SEND_ADDR_HI: w_byte = {2'b00, r_addr[13:8]};
      SEND_ADDR_LO: w_byte = r_addr[7:0];
      SEND_DATA_HI: w_byte = r_wdata[15:8];
      SEND_DATA_LO: w_byte = r_wdata[7:0];
      default:      w_byte = r_tx_data;
    endcase
  end

  // Next-state, strobe and response-value decode.
  // In a send state the strobe is issued only when the transmitter is idle
  // and no strobe was issued last cycle; the state advances the cycle after.
  always_comb begin
    w_next        = r_state;
    w_send        = 1'b0;
    w_rsp_data    = 16'h0000;
    w_rsp_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = SEND_CMD;
        else          w_next = IDLE;
      end
      SEND_CMD: begin
        if (r_tx_valid) w_next = r_spram ? SEND_ADDR_HI : SEND_ADDR_LO;
        else            w_send = !tx_busy;
      end
      SEND_ADDR_HI: begin
        if (r_tx_valid) w_next = SEND_ADDR_LO;
        else            w_send = !tx_busy;
      end
      SEND_ADDR_LO: begin
        if (r_tx_valid) w_next = r_write ? SEND_DATA_HI : TX_DRAIN;
        else            w_send = !tx_busy;
      end
      SEND_DATA_HI: begin
        if (r_tx_valid) w_next = SEND_DATA_LO;
        else            w_send = !tx_busy;
      end
      SEND_DATA_LO: begin
        if (r_tx_valid) w_next = TX_DRAIN;
        else            w_send = !tx_busy;
      end
      TX_DRAIN: begin
        if (!tx_busy) w_next = r_write ? RESP : RX_HI;
        else          w_next = TX_DRAIN;
      end
      RX_HI: begin
        // A byte arriving on the expiry cycle wins over the timeout.
        if (rx_valid) begin
          w_next = RX_LO;
        end else if (w_expire) begin
          w_next        = RESP;
          w_rsp_timeout = 1'b1;
        end else begin
          w_next = RX_HI;
        end
      end
      RX_LO: begin
        if (rx_valid) begin
          w_next     = RESP;
          w_rsp_data = {r_rx_hi, rx_data};
        end else if (w_expire) begin
          w_next        = RESP;
          w_rsp_timeout = 1'b1;
        end else begin
          w_next = RX_LO;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Capture request fields on acceptance so the client may change them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_write  <= 1'b0;
      r_spram  <= 1'b0;
      r_select <= '0;
      r_addr   <= 14'h0000;
      r_wdata  <= 16'h0000;
    end else if (w_accept) begin
      r_write  <= req_write;
      r_spram  <= req_spram;
      r_select <= req_select;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
    end
  end

  // Transmit strobe and byte; the byte holds until the next strobe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_valid <= w_send;
      if (w_send) r_tx_data <= w_byte;
    end
  end

  // Inter-byte timeout counter: zero outside the receive states and after
  // every accepted byte, counting up while waiting for one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                  r_cnt <= '0;
    else if (!w_in_rx || rx_valid) r_cnt <= '0;
    else                          r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // High response byte; rsp_data itself only changes when a response issues.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                          r_rx_hi <= 8'h00;
    else if (r_state == RX_HI && rx_valid) r_rx_hi <= rx_data;
  end

  // Response pulse, data and timeout flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_data    <= 16'h0000;
    end else begin
      r_rsp_valid   <= w_enter_resp;
      r_rsp_timeout <= w_enter_resp && w_rsp_timeout;
      if (w_enter_resp) r_rsp_data <= w_rsp_data;
    end
  end

  // Handshake/status flags registered from the next state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_req_ready <= (w_next == IDLE);
      r_busy      <= (w_next != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_cmd_initiator.sv
// Self-checking bench for uart_cmd_initiator: a reference model builds the
// expected frame bytes and responses from the request fields; a small
// transmitter model returns tx_busy for busy_len cycles after each strobe.
module tb_uart_cmd_initiator;
  localparam int SELW = 5;
  localparam int TMO  = 100;

  typedef logic [7:0] bytes_t[$];

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_write = 1'b0;
  logic            req_spram = 1'b0;
  logic [SELW-1:0] req_select = '0;
  logic [13:0]     req_addr = 14'h0;
  logic [15:0]     req_wdata = 16'h0;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_valid = 1'b0;
  logic            req_ready, rsp_valid, rsp_timeout, tx_valid, busy, tx_busy;
  logic [15:0]     rsp_data;
  logic [7:0]      tx_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_len = 0;
  int busy_cnt = 0;
  int busy_viol = 0;
  logic [7:0]  tx_log[$];
  logic [15:0] rsp_d_q[$];
  logic        rsp_t_q[$];
  int          rsp_c_q[$];

  uart_cmd_initiator #(.MEM_SELECT_BITS(SELW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_spram(req_spram), .req_select(req_select), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign tx_busy = (busy_cnt != 0);
  always @(posedge clk or negedge resetn) begin
    if (!resetn)           busy_cnt <= 0;
    else if (tx_valid)     busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  always @(posedge clk) begin
    if (resetn && tx_valid) begin
      tx_log.push_back(tx_data);
      if (tx_busy) busy_viol <= busy_viol + 1;
    end
    if (resetn && rsp_valid) begin
      rsp_d_q.push_back(rsp_data);
      rsp_t_q.push_back(rsp_timeout);
      rsp_c_q.push_back(cyc);
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: frame bytes for a request.
  function automatic bytes_t build_frame(input logic w, input logic sp,
      input logic [SELW-1:0] sel, input logic [13:0] a, input logic [15:0] d);
    bytes_t q;
    logic [5:0] sel6;
    sel6 = 6'(sel);
    q.push_back({w, sp, sel6});
    if (sp) q.push_back({2'b00, a[13:8]});
    q.push_back(a[7:0]);
    if (w) begin
      q.push_back(d[15:8]);
      q.push_back(d[7:0]);
    end
    return q;
  endfunction

  task automatic clear_logs;
    tx_log.delete(); rsp_d_q.delete(); rsp_t_q.delete(); rsp_c_q.delete();
  endtask

  task automatic scramble;
    req_write  = 1'($urandom);
    req_spram  = 1'($urandom);
    req_select = SELW'($urandom);
    req_addr   = 14'($urandom);
    req_wdata  = 16'($urandom);
  endtask

  task automatic issue(input logic w, input logic sp, input logic [SELW-1:0] sel,
                       input logic [13:0] a, input logic [15:0] d);
    int n = 0;
    while (req_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL issue_ready: req_ready=%b after %0d cycles, expected 1", req_ready, n);
    end
    req_valid = 1'b1; req_write = w; req_spram = sp; req_select = sel;
    req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    scramble();
  endtask

  // Waits until n_exp bytes were sent and the transmitter is idle; optionally
  // injects stray 0xFF bytes meanwhile. Returns the cycle of that observation.
  task automatic wait_tx_done(input int n_exp, input bit stray, output int d);
    int k = 0;
    bit done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if ((tx_log.size() >= n_exp && tx_busy == 1'b0) || k > 2000) begin
        done = 1'b1;
      end else begin
        k++;
        if (stray && $urandom_range(0, 3) == 0) begin rx_valid = 1'b1; rx_data = 8'hFF; end
        else rx_valid = 1'b0;
      end
    end
    rx_valid = 1'b0;
    d = cyc;
    checks++;
    if (k > 2000) begin
      errors++;
      $display("FAIL tx_done: sent %0d bytes, expected %0d", tx_log.size(), n_exp);
    end
  endtask

  task automatic wait_rsp(input int n, input int bound);
    int k = 0;
    while (rsp_d_q.size() < n && k < bound) begin @(negedge clk); k++; end
    checks++;
    if (rsp_d_q.size() < n) begin
      errors++;
      $display("FAIL rsp_wait: got %0d responses, expected %0d", rsp_d_q.size(), n);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_bytes(input string name, input bytes_t exp);
    checks++;
    if (tx_log.size() != exp.size()) begin
      errors++;
      $display("FAIL %s tx_count: got %0d, expected %0d", name, tx_log.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (tx_log[i] !== exp[i]) begin
          errors++;
          $display("FAIL %s tx_byte[%0d]: got %02h, expected %02h", name, i, tx_log[i], exp[i]);
        end
      end
    end
  endtask

  // Full transaction against the model: frame bytes, one response, data, idle.
  task automatic run_txn(input logic w, input logic sp, input logic [SELW-1:0] sel,
      input logic [13:0] a, input logic [15:0] d, input logic [15:0] rd,
      input bit stray, input string name);
    bytes_t exp;
    int dcyc;
    logic [15:0] exp_data;
    exp = build_frame(w, sp, sel, a, d);
    exp_data = w ? 16'h0000 : rd;
    clear_logs();
    issue(w, sp, sel, a, d);
    wait_tx_done(exp.size(), stray, dcyc);
    if (!w) begin
      repeat ($urandom_range(2, 4)) @(negedge clk);
      send_rx(rd[15:8]);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      send_rx(rd[7:0]);
    end
    wait_rsp(1, 500);
    repeat (3) @(negedge clk);
    check_bytes(name, exp);
    checks++;
    if (rsp_d_q.size() != 1) begin
      errors++;
      $display("FAIL %s rsp_count: got %0d, expected 1", name, rsp_d_q.size());
    end
    if (rsp_d_q.size() >= 1) begin
      checks++;
      if (rsp_d_q[0] !== exp_data) begin
        errors++;
        $display("FAIL %s rsp_data: got %04h, expected %04h", name, rsp_d_q[0], exp_data);
      end
      checks++;
      if (rsp_t_q[0] !== 1'b0) begin
        errors++;
        $display("FAIL %s rsp_timeout: got %b, expected 0", name, rsp_t_q[0]);
      end
    end
    checks++;
    if (rsp_data !== exp_data) begin
      errors++;
      $display("FAIL %s rsp_data_hold: got %04h, expected %04h", name, rsp_data, exp_data);
    end
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: req_ready=%b busy=%b, expected 1/0", name, req_ready, busy);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0 || rsp_valid !== 1'b0 ||
        rsp_timeout !== 1'b0 || tx_data !== 8'h00 || rsp_data !== 16'h0000) begin
      errors++;
      $display("FAIL %s: ready=%b busy=%b txv=%b rspv=%b to=%b txd=%02h rspd=%04h, expected 1 0 0 0 0 00 0000",
               name, req_ready, busy, tx_valid, rsp_valid, rsp_timeout, tx_data, rsp_data);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_bram;
    busy_len = 10;
    run_txn(1'b1, 1'b0, 5'd3, 14'h002A, 16'hBEEF, 16'h0000, 1'b0, "bram_write");
  endtask

  task automatic test_spram_read;
    busy_len = 10;
    run_txn(1'b0, 1'b1, 5'd1, 14'h1234, 16'h0000, 16'h5AC3, 1'b0, "spram_read");
  endtask

  task automatic check_timeout_rsp(input string name, input int exp_cyc);
    checks++;
    if (rsp_d_q.size() != 1) begin
      errors++;
      $display("FAIL %s count: got %0d responses, expected 1", name, rsp_d_q.size());
    end else begin
      checks++;
      if (rsp_c_q[0] != exp_cyc) begin
        errors++;
        $display("FAIL %s cycle: got %0d, expected %0d", name, rsp_c_q[0], exp_cyc);
      end
      checks++;
      if (rsp_t_q[0] !== 1'b1 || rsp_d_q[0] !== 16'h0000) begin
        errors++;
        $display("FAIL %s value: timeout=%b data=%04h, expected 1/0000", name, rsp_t_q[0], rsp_d_q[0]);
      end
    end
  endtask

  // The receive wait starts the cycle after the drain completes (d+1) or
  // after the last accepted byte (b+1); expiry follows TMO cycles later.
  task automatic test_timeout;
    int d, b;
    busy_len = 3;
    clear_logs();
    issue(1'b0, 1'b0, 5'd7, 14'h0055, 16'h0000);
    wait_tx_done(2, 1'b0, d);
    wait_rsp(1, TMO * 3);
    repeat (2) @(negedge clk);
    check_timeout_rsp("timeout_nobyte", d + 1 + TMO);
    clear_logs();
    issue(1'b0, 1'b1, 5'd2, 14'h2ABC, 16'h0000);
    wait_tx_done(3, 1'b0, d);
    repeat (3) @(negedge clk);
    b = cyc;
    send_rx(8'hA5);
    wait_rsp(1, TMO * 3);
    repeat (2) @(negedge clk);
    check_timeout_rsp("timeout_onebyte", b + 1 + TMO);
  endtask

  task automatic test_stray_rx;
    busy_len = 10;
    run_txn(1'b1, 1'b0, 5'd9, 14'h0077, 16'h1357, 16'h0000, 1'b1, "stray_write");
    run_txn(1'b0, 1'b0, 5'd4, 14'h0010, 16'h0000, 16'h0001, 1'b1, "stray_read");
  endtask

  task automatic test_back_to_back;
    bytes_t exp, e2;
    int k = 0;
    int viol0;
    logic [SELW-1:0] s1, s2;
    logic [13:0] a1, a2;
    logic [15:0] d1, d2;
    s1 = SELW'($urandom); a1 = 14'($urandom); d1 = 16'($urandom);
    s2 = SELW'($urandom); a2 = 14'($urandom); d2 = 16'($urandom);
    exp = build_frame(1'b1, 1'b0, s1, a1, d1);
    e2  = build_frame(1'b1, 1'b1, s2, a2, d2);
    foreach (e2[i]) exp.push_back(e2[i]);
    busy_len = 4;
    viol0 = busy_viol;
    clear_logs();
    req_valid = 1'b1; req_write = 1'b1; req_spram = 1'b0;
    req_select = s1; req_addr = a1; req_wdata = d1;
    @(negedge clk);
    while (rsp_d_q.size() == 0 && k < 1000) begin
      scramble();
      @(negedge clk);
      k++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: req_ready=%b after rsp_valid, expected 1", req_ready);
    end
    req_write = 1'b1; req_spram = 1'b1; req_select = s2; req_addr = a2; req_wdata = d2;
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(2, 1000);
    repeat (3) @(negedge clk);
    check_bytes("b2b", exp);
    checks++;
    if (rsp_d_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_rsp_count: got %0d, expected 2", rsp_d_q.size());
    end
    checks++;
    if (busy_viol != viol0) begin
      errors++;
      $display("FAIL b2b_tx_while_busy: got %0d strobes, expected 0", busy_viol - viol0);
    end
  endtask

  task automatic test_reset_mid_frame;
    int k = 0;
    busy_len = 10;
    clear_logs();
    issue(1'b1, 1'b0, 5'd6, 14'h005C, 16'hCAFE);
    while (tx_log.size() < 2 && k < 500) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tx_data !== 8'h5C) begin
      errors++;
      $display("FAIL midframe_pre: busy=%b tx_data=%02h, expected 1/5c", busy, tx_data);
    end
    #2 resetn = 1'b0;
    #1;
    check_reset_values("async_reset");
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (rsp_d_q.size() != 0 || tx_log.size() != 2) begin
      errors++;
      $display("FAIL midframe_abort: rsp=%0d tx_bytes=%0d, expected 0/2", rsp_d_q.size(), tx_log.size());
    end
    run_txn(1'b0, 1'b1, 5'd11, 14'h3F01, 16'h0000, 16'h9E37, 1'b0, "after_reset_read");
  endtask

  task automatic test_random;
    for (int i = 0; i < 16; i++) begin
      busy_len = $urandom_range(0, 10);
      run_txn(1'($urandom), 1'($urandom), SELW'($urandom), 14'($urandom),
              16'($urandom), 16'($urandom), 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_write_bram();
    test_spram_read();
    test_timeout();
    test_stray_rx();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    checks++;
    if (busy_viol != 0) begin
      errors++;
      $display("FAIL tx_while_busy: got %0d strobes, expected 0", busy_viol);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
